// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types, default widths and read-side helpers
package fifo_pkg;

    localparam int DEF_DATA_W = 32;

    typedef logic [1:0] occ_t;

    // Room exists for one more read once the current pop is taken into account.
    function automatic logic has_room(occ_t occ, logic inflight, logic pop);
        return ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - two-entry register buffer presenting its head entry
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output occ_t              occ
);

    logic [DATA_W-1:0] e0_q, e0_d;
    logic [DATA_W-1:0] e1_q, e1_d;
    occ_t              occ_q, occ_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) e0_d = din;
                else               e1_d = din;
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - 2'd1;
            end
            // Simultaneous push/pop: the new word lands behind whatever stays.
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = din;
                end else begin
                    e0_d = e1_q;
                    e1_d = din;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign head = e0_q;
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read engine re-presenting words as a valid/ready stream
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  rd_count
);

    occ_t             occ;
    logic             pop;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;

    skid_buf2 #(.DATA_W(DATA_W)) u_buf (
        .clk   (clk),
        .rst_n (rst),
        .push  (inflight_q),
        .pop   (pop),
        .din   (fifo_data),
        .head  (m_data),
        .occ   (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid & m_ready;

    // Gating with rst keeps the strobe low for the whole reset, not just after the edge.
    always_comb begin
        fifo_rd    = rst & en & ~fifo_empty & has_room(occ, inflight_q, pop);
        inflight_d = fifo_rd;
        count_d    = pop ? count_q + CNT_W'(1) : count_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
        end
    end

    assign rd_count = count_q;

    always_ff @(posedge clk) begin
        if (rst) assert (({1'b0, occ} + {2'b00, inflight_q}) <= 3'd2);
    end

endmodule
